dct_pass_scheduler: RTL and testbench
=====================================

Name: dct_pass_scheduler

Overview:
- Sequences one shared 1D binDCT core (fbindct-style load/valid_out interface) through both passes of an 8x8 2D DCT: 8 row passes, then 8 column passes.
- Owns the 8x8 transpose buffer and a per-issue watchdog.
- Upstream supplies one input row per valid/ready beat; downstream receives one coefficient column per valid/ready beat.
- Replaces the two-core 2D arrangement where core area matters more than throughput.

Parameters:
- IN_WIDTH, 8: signed input sample width.
- DW, 20: core vector element width; buffer and output element width.
- TIMEOUT, 64: maximum cycles from core_load to core_valid before abort.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  input row valid
- in_ready  out  1  scheduler accepts input row
- in_row  in  8*IN_WIDTH  row samples; element i at bits [i*IN_WIDTH +: IN_WIDTH]
- core_load  out  1  one-cycle start pulse to shared core
- core_x  out  8*DW  core operand vector; element i at [i*DW +: DW]
- core_ready  out  1  scheduler will capture core result
- core_valid  in  1  core result valid
- core_y  in  8*DW  core result vector
- out_valid  out  1  output column valid
- out_ready  in  1  downstream accepts column
- out_col  out  8*DW  final coefficients of column out_idx; element i = row i
- out_idx  out  3  column index of out_col
- out_last  out  1  high with out_valid when out_idx==7
- busy  out  1  high in any state except ROW_IN with row count 0
- block_done  out  1  one-cycle pulse when column 7 is accepted
- err  out  2  sticky; bit0 = timeout, bit1 = spurious core_valid

Behaviour:
- Reset: rst is synchronous, active-high, on clk.
  - State ROW_IN; row counter r=0, column counter c=0.
  - in_ready=1; core_load=0, core_x=0, core_ready=0.
  - out_valid=0, out_col=0, out_idx=0, out_last=0; block_done=0, err=0.
  - Buffer contents are don't-care.
  - rst mid-block discards all partial state.
- ROW_IN (in_ready=1): on in_valid&&in_ready:
  - core_x <= each element sign-extended IN_WIDTH->DW.
  - Go to ROW_WAIT.
- ROW_WAIT:
  - in_ready=0, core_ready=1.
  - core_load=1 on the first cycle only; core_x is held stable for the whole state.
  - On core_valid: buffer[r][i] <= core_y[i].
  - If r==7 go to COL_ISSUE with c=0; else r<=r+1 and go to ROW_IN.
- COL_ISSUE (one cycle): core_x[i] <= buffer[i][c]; go to COL_WAIT.
  - The buffer write of row 7 is visible here; no bypass is needed.
- COL_WAIT:
  - Same core_load and core_x rules as ROW_WAIT.
  - On core_valid: out_col <= core_y, out_idx <= c, out_valid <= 1; go to COL_OUT.
- COL_OUT: out_valid and out_col are held until out_ready. On out_valid&&out_ready:
  - out_valid <= 0.
  - If c==7: block_done pulse; r<=0, c<=0; go to ROW_IN.
  - Else c<=c+1; go to COL_ISSUE.
- Backpressure: the core is never issued while an output column is pending; at most one core operation is outstanding.
- Watchdog:
  - Counter clears on entry to ROW_WAIT or COL_WAIT and increments each cycle in those states.
  - If it reaches TIMEOUT without core_valid: err[0] <= 1, abort to ROW_IN with r=c=0, out_valid=0.
  - core_valid on the same cycle as expiry is accepted as a normal result; no error is raised.
- Spurious result: core_valid outside ROW_WAIT/COL_WAIT sets err[1]; the data is ignored and state is unchanged.
- err clears only on rst.
- Arithmetic: the scheduler does no arithmetic beyond sign extension. The core must accept DW-bit operands and return DW-bit results.
- Latency, with core latency L (core_load to core_valid):
  - Each row: 1 accept cycle + L.
  - Each column: 1 issue cycle + L + output handshake cycles.
  - With in_valid and out_ready held high: 8*(L+1) + 8*(L+2) cycles from first accept to block_done.

Test Plan:
- Core model with L=3 and identity transfer (y=x); input rows all 8'sd1, in_valid and out_ready held high. Expect 8 output columns, every element 20'sd1, out_idx 0..7, out_last on the 8th, block_done at cycle 8*4+8*5=72 from first accept.
- Transpose check, identity core: in_row[r][i]=8*r+i. Expect out_col element i of column c = 8*i+c; input -128 must appear as 20'sh_FFF80.
- Backpressure: hold out_ready=0 for 10 cycles on column 3. Expect out_valid and out_col stable; no core_load pulse; column 4 issued on the cycle after acceptance.
- Timeout: TIMEOUT=64; core never asserts core_valid on row 2. Expect err=2'b01 after 64 cycles in ROW_WAIT, state back to ROW_IN with in_ready=1; the next full block completes correctly with err still 01.
- Spurious and boundary: pulse core_valid while in ROW_IN. Expect err[1]=1 with no state change. Then core_valid exactly at watchdog expiry: expect the result accepted and err[0] unchanged.
- rst asserted during COL_OUT of column 5. Expect all outputs at reset values on the next cycle; the next block's output is unaffected by stale data.

Source files
------------

// File: rtl/dct_pass_scheduler.sv
// Drives one shared 1D DCT core through 8 row passes, then 8 column passes via an 8x8 transpose buffer.
// One core op in flight at a time; per-op watchdog; column output is held until out_ready and stalls further issues.
module dct_pass_scheduler #(
    parameter int IN_WIDTH = 8,
    parameter int DW       = 20,
    parameter int TIMEOUT  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*IN_WIDTH-1:0] in_row,
    output logic                  core_load,
    output logic [8*DW-1:0]       core_x,
    output logic                  core_ready,
    input  logic                  core_valid,
    input  logic [8*DW-1:0]       core_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*DW-1:0]       out_col,
    output logic [2:0]            out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  block_done,
    output logic [1:0]            err
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ROW_IN,
        ROW_WAIT,
        COL_ISSUE,
        COL_WAIT,
        COL_OUT
    } state_t;

    state_t           state_q;
    logic [2:0]       row_q;
    logic [2:0]       col_q;
    logic [WDW-1:0]   wd_q;
    logic             core_load_q;
    logic [8*DW-1:0]  core_x_q;
    logic             out_valid_q;
    logic [8*DW-1:0]  out_col_q;
    logic [2:0]       out_idx_q;
    logic             out_last_q;
    logic             block_done_q;
    logic [1:0]       err_q;
    logic [DW-1:0]    tbuf_q [8][8];

    logic in_wait;
    logic wd_expired;

    assign in_wait    = (state_q == ROW_WAIT) || (state_q == COL_WAIT);
    assign wd_expired = (wd_q == WDW'(TIMEOUT - 1));

    assign in_ready   = (state_q == ROW_IN);
    assign core_ready = in_wait;
    assign busy       = !((state_q == ROW_IN) && (row_q == 3'd0));
    assign core_load  = core_load_q;
    assign core_x     = core_x_q;
    assign out_valid  = out_valid_q;
    assign out_col    = out_col_q;
    assign out_idx    = out_idx_q;
    assign out_last   = out_last_q;
    assign block_done = block_done_q;
    assign err        = err_q;

    // Row results land in buffer row r; columns are read back across rows.
    always_ff @(posedge clk) begin
        if (state_q == ROW_WAIT && core_valid) begin
            for (int i = 0; i < 8; i++) begin
                tbuf_q[row_q][i] <= core_y[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ROW_IN;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            wd_q         <= '0;
            core_load_q  <= 1'b0;
            core_x_q     <= '0;
            out_valid_q  <= 1'b0;
            out_col_q    <= '0;
            out_idx_q    <= 3'd0;
            out_last_q   <= 1'b0;
            block_done_q <= 1'b0;
            err_q        <= 2'b00;
        end else begin
            core_load_q  <= 1'b0;
            block_done_q <= 1'b0;
            if (core_valid && !in_wait) begin
                err_q[1] <= 1'b1;
            end
            case (state_q)
                ROW_IN: begin
                    if (in_valid) begin
                        for (int i = 0; i < 8; i++) begin
                            core_x_q[i*DW +: DW] <= DW'($signed(in_row[i*IN_WIDTH +: IN_WIDTH]));
                        end
                        core_load_q <= 1'b1;
                        wd_q        <= '0;
                        state_q     <= ROW_WAIT;
                    end
                end
                ROW_WAIT: begin
                    if (core_valid) begin
                        if (row_q == 3'd7) begin
                            col_q   <= 3'd0;
                            state_q <= COL_ISSUE;
                        end else begin
                            row_q   <= row_q + 3'd1;
                            state_q <= ROW_IN;
                        end
                    end else if (wd_expired) begin
                        err_q[0] <= 1'b1;
                        row_q    <= 3'd0;
                        col_q    <= 3'd0;
                        state_q  <= ROW_IN;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                COL_ISSUE: begin
                    for (int i = 0; i < 8; i++) begin
                        core_x_q[i*DW +: DW] <= tbuf_q[i][col_q];
                    end
                    core_load_q <= 1'b1;
                    wd_q        <= '0;
                    state_q     <= COL_WAIT;
                end
                COL_WAIT: begin
                    if (core_valid) begin
                        out_col_q   <= core_y;
                        out_idx_q   <= col_q;
                        out_last_q  <= (col_q == 3'd7);
                        out_valid_q <= 1'b1;
                        state_q     <= COL_OUT;
                    end else if (wd_expired) begin
                        err_q[0]    <= 1'b1;
                        row_q       <= 3'd0;
                        col_q       <= 3'd0;
                        out_valid_q <= 1'b0;
                        state_q     <= ROW_IN;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                COL_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (col_q == 3'd7) begin
                            block_done_q <= 1'b1;
                            row_q        <= 3'd0;
                            col_q        <= 3'd0;
                            state_q      <= ROW_IN;
                        end else begin
                            col_q   <= col_q + 3'd1;
                            state_q <= COL_ISSUE;
                        end
                    end
                end
                default: begin
                    state_q <= ROW_IN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dct_pass_scheduler.sv
// Bench for dct_pass_scheduler: identity core model, column scoreboard, watchdog/spurious/reset scenarios.
module tb_dct_pass_scheduler;

    localparam int IW = 8;
    localparam int DW = 20;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [8*IW-1:0]   in_row;
    logic              core_load;
    logic [8*DW-1:0]   core_x;
    logic              core_ready;
    logic              core_valid;
    logic [8*DW-1:0]   core_y;
    logic              out_valid;
    logic              out_ready;
    logic [8*DW-1:0]   out_col;
    logic [2:0]        out_idx;
    logic              out_last;
    logic              busy;
    logic              block_done;
    logic [1:0]        err;

    dct_pass_scheduler #(.IN_WIDTH(IW), .DW(DW), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .core_load(core_load), .core_x(core_x), .core_ready(core_ready),
        .core_valid(core_valid), .core_y(core_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
        .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .block_done(block_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]      idx;
        logic [8*DW-1:0] col;
    } exp_t;

    exp_t              sb_q[$];
    logic signed [7:0] blk [8][8];
    int checks = 0;
    int fails  = 0;

    int  core_lat = 3;
    bit  core_mute = 0;
    int  spur_req = 0;
    int  spur_ack = 0;
    int  core_cnt = 0;
    logic [8*DW-1:0] core_lat_x;

    bit  bp_arm = 0;
    int  bp_cnt = 0;
    int  bp_acc_cyc = -1;
    logic [8*DW-1:0] bp_col;
    bit  rst_arm = 0;
    bit  at5_seen = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  acc0_cyc = 0;

    task automatic check_eq(input string tag, input logic [8*DW-1:0] obs, input logic [8*DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},   in_ready, 1);
        check_eq({tag, "_core_load"},  core_load, 0);
        check_eq({tag, "_core_x"},     core_x, 0);
        check_eq({tag, "_core_ready"}, core_ready, 0);
        check_eq({tag, "_out_valid"},  out_valid, 0);
        check_eq({tag, "_out_col"},    out_col, 0);
        check_eq({tag, "_out_idx"},    out_idx, 0);
        check_eq({tag, "_out_last"},   out_last, 0);
        check_eq({tag, "_block_done"}, block_done, 0);
        check_eq({tag, "_err"},        err, 0);
        check_eq({tag, "_busy"},       busy, 0);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic send_block(input int nrows);
        exp_t e;
        for (int r = 0; r < nrows; r++) begin
            int t = 0;
            while (!in_ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                check_eq("row_accept_timeout", 0, 1);
                return;
            end
            in_valid = 1'b1;
            for (int i = 0; i < 8; i++) in_row[i*IW +: IW] = blk[r][i];
            if (r == 0) acc0_cyc = cyc;
            @(negedge clk);
            in_valid = 1'b0;
        end
        if (nrows == 8) begin
            for (int c = 0; c < 8; c++) begin
                e.idx = 3'(c);
                for (int i = 0; i < 8; i++) e.col[i*DW +: DW] = {{(DW-IW){blk[i][c][7]}}, blk[i][c]};
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) check_eq({tag, "_done_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_row = '0;
        core_valid = 1'b0;
        core_y = '0;
        out_ready = 1'b1;

        fork
            forever begin : core_model
                @(negedge clk);
                core_valid = 1'b0;
                if (spur_req != spur_ack) begin
                    core_valid = 1'b1;
                    core_y = {8{20'h12345}};
                    spur_ack = spur_req;
                end
                if (core_cnt > 0) begin
                    core_cnt--;
                    if (core_cnt == 0) begin
                        core_valid = 1'b1;
                        core_y = core_lat_x;
                    end
                end
                if (core_load && !core_mute) begin
                    core_lat_x = core_x;
                    core_cnt = core_lat - 1;
                end
            end
            forever begin : out_monitor
                exp_t e;
                @(negedge clk);
                if (core_load && bp_acc_cyc >= 0) begin
                    check_eq("bp_next_issue_gap", cyc - bp_acc_cyc, 2);
                    bp_acc_cyc = -1;
                end
                if (rst_arm && out_valid && out_idx == 3'd5) begin
                    out_ready = 1'b0;
                    at5_seen = 1'b1;
                end else if (bp_arm && out_valid && out_idx == 3'd3) begin
                    if (bp_cnt == 0) bp_col = out_col;
                    if (bp_cnt < 10) begin
                        out_ready = 1'b0;
                        check_eq("bp_col_stable", out_col, bp_col);
                        check_eq("bp_no_core_load", core_load, 0);
                        bp_cnt++;
                    end else begin
                        out_ready = 1'b1;
                        bp_arm = 1'b0;
                        bp_acc_cyc = cyc;
                    end
                end else begin
                    out_ready = 1'b1;
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check_eq("sb_unexpected_col", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("col_data", out_col, e.col);
                        check_eq("col_idx", out_idx, e.idx);
                        check_eq("col_last", out_last, (e.idx == 3'd7));
                    end
                end
                if (block_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // All-ones block with throughput timing
        for (int r = 0; r < 8; r++) for (int i = 0; i < 8; i++) blk[r][i] = 8'sd1;
        send_block(8);
        wait_done(300, "ones");
        check_eq("ones_done_latency", done_cyc - acc0_cyc, 72);
        check_eq("ones_sb_drained", sb_q.size(), 0);

        // Transpose pattern with a -128 corner, plus backpressure on column 3
        for (int r = 0; r < 8; r++) for (int i = 0; i < 8; i++) blk[r][i] = 8'(8*r + i);
        blk[7][7] = -8'sd128;
        bp_arm = 1'b1;
        bp_cnt = 0;
        send_block(8);
        wait_done(400, "transpose");
        check_eq("bp_hold_cycles", bp_cnt, 10);
        check_eq("transpose_sb_drained", sb_q.size(), 0);

        // Core stalls forever on row 2
        for (int r = 0; r < 8; r++) for (int i = 0; i < 8; i++) blk[r][i] = 8'(r - 3*i);
        send_block(2);
        begin
            int n = 0;
            int t = 0;
            core_mute = 1'b1;
            while (!in_ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            while (!in_ready && n < 200) begin
                n++;
                @(negedge clk);
            end
            check_eq("timeout_wait_cycles", n, 64);
            check_eq("timeout_err", err, 2'b01);
            check_eq("timeout_in_ready", in_ready, 1);
            check_eq("timeout_busy", busy, 0);
            core_mute = 1'b0;
        end
        send_block(8);
        wait_done(400, "post_timeout");
        check_eq("post_timeout_err", err, 2'b01);
        check_eq("post_timeout_sb_drained", sb_q.size(), 0);

        // Spurious core_valid while idle in ROW_IN
        spur_req++;
        repeat (3) @(negedge clk);
        check_eq("spur_err", err, 2'b11);
        check_eq("spur_in_ready", in_ready, 1);
        check_eq("spur_busy", busy, 0);
        check_eq("spur_out_valid", out_valid, 0);

        // Every core result lands on the watchdog's last cycle
        core_lat = 64;
        for (int r = 0; r < 8; r++) for (int i = 0; i < 8; i++) blk[r][i] = 8'(5*i - 7*r);
        send_block(8);
        wait_done(3000, "expiry_edge");
        check_eq("expiry_edge_err", err, 2'b11);
        check_eq("expiry_edge_sb_drained", sb_q.size(), 0);
        core_lat = 3;

        // Reset while column 5 is pending
        rst_arm = 1'b1;
        at5_seen = 1'b0;
        send_block(8);
        begin
            int t = 0;
            while (!at5_seen && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (!at5_seen) check_eq("col5_timeout", 0, 1);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        rst_arm = 1'b0;
        sb_q.delete();
        @(negedge clk);
        for (int r = 0; r < 8; r++) for (int i = 0; i < 8; i++) blk[r][i] = 8'(100 - 11*r + 2*i);
        send_block(8);
        wait_done(300, "after_rst");
        check_eq("after_rst_sb_drained", sb_q.size(), 0);
        check_eq("after_rst_err", err, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
